seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
Parametrised, runtime-programmable serial bit-pattern detector, the successor to the fixed 4-bit pattern detectors in the FSM library.
- Pattern length, default pattern and counter width are parameters.
- Pattern and overlap mode are reloadable at runtime.
- Input bits are qualified by a valid strobe.
- A saturating match counter is provided.
- Sits on a serial bit stream ahead of framing/sync logic; emits a one-cycle registered match pulse.

Parameters:
LEN, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1011 (LEN bits), pattern loaded at reset; bit LEN-1 is the first bit received, bit 0 the last.
OVERLAP_DEFAULT, 1, overlap mode at reset (1 = overlapping, 0 = non-overlapping).
COUNT_W, 8, width of the match counter.

Ports:
clk  in  1  clock, all state on rising edge.
clear  in  1  asynchronous active-high reset.
in  in  1  serial data bit.
in_valid  in  1  qualifies in; a bit is consumed only on an edge where in_valid=1.
pat_load  in  1  load strobe for pat_in/overlap_in.
pat_in  in  LEN  new pattern, same bit ordering as PATTERN.
overlap_in  in  1  new overlap mode.
count_clr  in  1  synchronous clear of match_count.
match  out  1  registered pulse; high one cycle after the edge that accepted the final pattern bit.
match_count  out  COUNT_W  saturating number of matches since reset/clear.
armed  out  1  high when the history holds LEN valid bits (state ARMED).

Behaviour:
- Reset (clear=1, async): pattern=PATTERN, overlap=OVERLAP_DEFAULT, hist=0, fill=0, state=IDLE, match=0, match_count=0, armed=0.
- History: LEN-bit shift register. On accepted bit, hist <= {hist[LEN-2:0], in}. fill counts accepted bits and saturates at LEN.
- States:
  - IDLE: fill=0.
  - FILL: 0<fill<LEN.
  - ARMED: fill=LEN.
  - Transitions occur only on accepted bits, pat_load, or reset.
- Match condition is evaluated on the updated values: new_fill==LEN and new_hist==pattern. It sets match=1 for exactly one cycle; otherwise match=0, including any cycle with in_valid=0.
- Latency: match is high in the cycle following the clock edge that consumed the last pattern bit. Equivalent to the Moore output of a fixed detector.
- Overlap=1: after a match, fill stays LEN, so a suffix of the match may begin the next match.
- Overlap=0: after a match, fill<=0 and state<=IDLE. The next LEN accepted bits must be entirely fresh.
- pat_load=1:
  - Effects: pattern<=pat_in, overlap<=overlap_in, hist<=0, fill<=0, state<=IDLE, match<=0.
  - An in_valid bit on the same edge is discarded.
  - match_count is unaffected.
- match_count:
  - Increments by 1 on each match edge.
  - Saturates at 2^COUNT_W-1; no wrap.
  - count_clr sets it to 0 and wins over a simultaneous match; that match still pulses match but is not counted.
- A match never fires with fill<LEN, even if the zeroed history equals the pattern (e.g. pattern all zeros).
- Reset asserted mid-stream aborts a partial match immediately. After release, detection restarts from IDLE with the default pattern and mode.
- armed = (state==ARMED), registered.

Decomposition:
- Shared package seq_detect_pkg holds:
  - state typedef/encoding: IDLE=2'b00, FILL=2'b01, ARMED=2'b10.
  - default constants for PATTERN and OVERLAP_DEFAULT.
- One natural sub-module: sat_counter (COUNT_W, inc, clr, value), the saturating match counter with clr priority.
- Shift/compare/state logic stays in the top module.

Test Plan:
1. Defaults (1011, overlap), stream 1,0,1,1,0,1,1 all valid -> match pulses after bits 4 and 7; match_count=2.
2. Load pat_in=1011, overlap_in=0, then stream 1,0,1,1,0,1,1,1,0,1,1 -> match after bits 4 and 11 only, not 7; match_count=2.
3. Load pat_in=0110, stream 0,1,1,0 with in_valid low for 3 idle cycles between bits -> single match pulse one cycle after the 4th accepted bit; match low during idle cycles.
4. COUNT_W=2, 5 overlapping matches -> match_count sequence 1,2,3,3,3. Then count_clr coincident with a match -> match=1, match_count=0.
5. pat_load on the same edge as in_valid=1 -> bit discarded, armed=0, fill restarts. A pattern of all zeros plus 3 zero bits -> no match until the 4th zero.
6. Assert clear after 1,0,1 of the default pattern, release, send 1 -> no match. Then 1,0,1,1 -> match; all outputs 0 while clear is high.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the programmable serial pattern detector:
//   - state encoding (IDLE / FILL / ARMED)
//   - default pattern and default overlap mode used at reset
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    // Detector state encoding, kept as plain 2-bit constants so that legacy
    // framing logic can decode it directly.
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t FILL  = 2'b01;
    localparam state_t ARMED = 2'b10;

    // Reset-time defaults; bit 3 of the pattern is the first bit received.
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam logic       DEF_OVERLAP = 1'b1;

endpackage : seq_detect_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a synchronous clear that has priority over inc.
// Ports:
//   clk    : clock, rising edge
//   clear  : asynchronous active-high reset (value -> 0)
//   inc    : add one on this edge unless already at the maximum value
//   clr    : synchronous clear, wins over a simultaneous inc
//   value  : registered count, sticks at 2^COUNT_W-1
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] value
);

    localparam logic [COUNT_W-1:0] MAX_VAL  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] ZERO_VAL = {COUNT_W{1'b0}};

    logic [COUNT_W-1:0] value_r;

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            value_r <= ZERO_VAL;
        end else if (clr) begin
            value_r <= ZERO_VAL;
        end else if (inc && (value_r != MAX_VAL)) begin
            value_r <= value_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule : sat_counter

// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
// Runtime-programmable serial bit-pattern detector with a saturating match
// counter.
// Ports:
//   clk         : clock, all state on rising edge
//   clear       : asynchronous active-high reset
//   in          : serial data bit
//   in_valid    : a bit is consumed only on edges where this is high
//   pat_load    : load pat_in / overlap_in, restart detection (same-edge bit dropped)
//   pat_in      : new pattern, bit LEN-1 is the first bit received
//   overlap_in  : new overlap mode (1 = overlapping)
//   count_clr   : synchronous clear of match_count (wins over a match)
//   match       : registered one-cycle pulse after the edge taking the last bit
//   match_count : saturating number of matches
//   armed       : registered, high while LEN valid bits are held
// -----------------------------------------------------------------------------
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int             LEN             = 4,
    parameter logic [LEN-1:0] PATTERN         = LEN'(DEF_PATTERN),
    parameter logic           OVERLAP_DEFAULT = DEF_OVERLAP,
    parameter int             COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               in,
    input  logic               in_valid,
    input  logic               pat_load,
    input  logic [LEN-1:0]     pat_in,
    input  logic               overlap_in,
    input  logic               count_clr,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic               armed
);

    localparam int             FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0]  FILL_ZERO = {FW{1'b0}};
    localparam logic [FW-1:0]  FILL_ONE  = FW'(1);
    localparam logic [LEN-1:0] HIST_ZERO = {LEN{1'b0}};

    logic [LEN-1:0] pattern_r;
    logic           overlap_r;
    logic [LEN-1:0] hist_r;
    logic [FW-1:0]  fill_r;
    state_t         state_r;
    logic           match_r;
    logic           armed_r;

    logic [LEN-1:0] pattern_s;
    logic           overlap_s;
    logic [LEN-1:0] hist_s;
    logic [FW-1:0]  fill_s;
    state_t         state_s;
    logic           match_s;
    logic [LEN-1:0] hist_upd_s;
    logic [FW-1:0]  fill_upd_s;
    logic           hit_s;

    // Shifted history and saturating fill for the bit offered this cycle.
    always_comb begin
        hist_upd_s = {hist_r[LEN-2:0], in};
        case (state_r)
            ARMED:   fill_upd_s = FILL_FULL;
            IDLE:    fill_upd_s = FILL_ONE;
            FILL:    fill_upd_s = fill_r + FILL_ONE;
            default: fill_upd_s = FILL_ZERO;
        endcase
        // Requiring a full history blocks false hits on the zeroed register.
        hit_s = (fill_upd_s == FILL_FULL) && (hist_upd_s == pattern_r);
    end

    // Next-state selection: pattern load beats data, idle cycles hold.
    always_comb begin
        pattern_s = pattern_r;
        overlap_s = overlap_r;
        hist_s    = hist_r;
        fill_s    = fill_r;
        match_s   = 1'b0;
        if (pat_load) begin
            pattern_s = pat_in;
            overlap_s = overlap_in;
            hist_s    = HIST_ZERO;
            fill_s    = FILL_ZERO;
        end else if (in_valid) begin
            hist_s  = hist_upd_s;
            match_s = hit_s;
            // Non-overlapping mode demands LEN fresh bits after each match.
            if (hit_s && !overlap_r) begin
                fill_s = FILL_ZERO;
            end else begin
                fill_s = fill_upd_s;
            end
        end else begin
            match_s = 1'b0;
        end
    end

    // State follows directly from the fill level.
    always_comb begin
        if (fill_s == FILL_ZERO) begin
            state_s = IDLE;
        end else if (fill_s == FILL_FULL) begin
            state_s = ARMED;
        end else begin
            state_s = FILL;
        end
    end

    // Detector state registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pattern_r <= PATTERN;
            overlap_r <= OVERLAP_DEFAULT;
            hist_r    <= HIST_ZERO;
            fill_r    <= FILL_ZERO;
            state_r   <= IDLE;
            match_r   <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            pattern_r <= pattern_s;
            overlap_r <= overlap_s;
            hist_r    <= hist_s;
            fill_r    <= fill_s;
            state_r   <= state_s;
            match_r   <= match_s;
            armed_r   <= (state_s == ARMED);
        end
    end

    sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_count (
        .clk   (clk),
        .clear (clear),
        .inc   (match_s),
        .clr   (count_clr),
        .value (match_count)
    );

    assign match = match_r;
    assign armed = armed_r;

endmodule : seq_detect_prog

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       overlap_in = 1'b0;
    logic       count_clr = 1'b0;

    logic       match8, match2, armed8, armed2;
    logic [7:0] count8;
    logic [1:0] count2;

    int total = 0;
    int bad   = 0;

    // Behavioural model: bits accepted since the last restart (at most LEN kept).
    bit   q[$];
    bit [3:0] m_pat;
    bit   m_ovl;
    int   m_cnt8, m_cnt2;
    bit   e_match, e_armed;

    always #5 clk = ~clk;

    seq_detect_prog #(.LEN(4), .COUNT_W(8)) dut8 (
        .clk(clk), .clear(clear), .in(in), .in_valid(in_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_in(overlap_in),
        .count_clr(count_clr), .match(match8), .match_count(count8), .armed(armed8)
    );

    seq_detect_prog #(.LEN(4), .COUNT_W(2)) dut2 (
        .clk(clk), .clear(clear), .in(in), .in_valid(in_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_in(overlap_in),
        .count_clr(count_clr), .match(match2), .match_count(count2), .armed(armed2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_pat   = 4'b1011;
        m_ovl   = 1'b1;
        q.delete();
        m_cnt8  = 0;
        m_cnt2  = 0;
        e_match = 1'b0;
        e_armed = 1'b0;
    endfunction

    function automatic void m_edge(bit v, bit b, bit ld, bit [3:0] pin, bit oin, bit cc);
        bit hit;
        int val;
        hit = 1'b0;
        if (ld) begin
            m_pat = pin;
            m_ovl = oin;
            q.delete();
        end else if (v) begin
            q.push_back(b);
            if (q.size() > LEN) void'(q.pop_front());
            if (q.size() == LEN) begin
                val = 0;
                foreach (q[i]) val = val * 2 + int'(q[i]);
                hit = (val == int'(m_pat));
            end
            if (hit && !m_ovl) q.delete();
        end
        e_match = hit;
        if (cc) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        e_armed = (q.size() == LEN);
    endfunction

    // Compare process: every output of both instances against the model.
    always @(negedge clk) begin
        chk("match8", 32'(match8), 32'(e_match));
        chk("match2", 32'(match2), 32'(e_match));
        chk("count8", 32'(count8), 32'(m_cnt8));
        chk("count2", 32'(count2), 32'(m_cnt2));
        chk("armed8", 32'(armed8), 32'(e_armed));
        chk("armed2", 32'(armed2), 32'(e_armed));
    end

    task automatic cyc(input bit v, input bit b, input bit ld, input bit [3:0] pin,
                       input bit oin, input bit cc);
        in_valid   = v;
        in         = b;
        pat_load   = ld;
        pat_in     = pin;
        overlap_in = oin;
        count_clr  = cc;
        @(posedge clk);
        m_edge(v, b, ld, pin, oin, cc);
        #1;
    endtask

    task automatic bit_in(input bit b);
        cyc(1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic load(input bit [3:0] p, input bit o);
        cyc(1'b0, 1'b0, 1'b1, p, o, 1'b1);
    endtask

    task automatic do_clear(input int n);
        in_valid = 1'b0;
        pat_load = 1'b0;
        count_clr = 1'b0;
        clear = 1'b1;
        m_reset();
        #1;
        chk("clr_match", 32'(match8), 32'd0);
        chk("clr_count", 32'(count8), 32'd0);
        chk("clr_armed", 32'(armed8), 32'd0);
        repeat (n) @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        bit [3:0] rp;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count8), 32'd0);
        clear = 1'b0;

        // 1: default pattern, overlapping
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("t1_match4", 32'(match8), 32'd1);
        chk("t1_armed4", 32'(armed8), 32'd1);
        bit_in(0);
        chk("t1_match5", 32'(match8), 32'd0);
        bit_in(1); bit_in(1);
        chk("t1_match7", 32'(match8), 32'd1);
        chk("t1_count", 32'(count8), 32'd2);
        idle();
        chk("t1_idle", 32'(match8), 32'd0);

        // 2: non-overlapping
        load(4'b1011, 1'b0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("t2_match4", 32'(match8), 32'd1);
        chk("t2_armed4", 32'(armed8), 32'd0);
        bit_in(0); bit_in(1); bit_in(1);
        chk("t2_match7", 32'(match8), 32'd0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("t2_match11", 32'(match8), 32'd1);
        chk("t2_count", 32'(count8), 32'd2);

        // 3: gaps in the valid strobe
        load(4'b0110, 1'b1);
        bit_in(0); repeat (3) idle();
        bit_in(1); repeat (3) idle();
        bit_in(1); repeat (3) idle();
        bit_in(0);
        chk("t3_match", 32'(match8), 32'd1);
        idle();
        chk("t3_after", 32'(match8), 32'd0);

        // 4: saturation of the narrow counter, then clear beating a match
        load(4'b1111, 1'b1);
        repeat (3) bit_in(1);
        bit_in(1); chk("t4_c1", 32'(count2), 32'd1);
        bit_in(1); chk("t4_c2", 32'(count2), 32'd2);
        bit_in(1); chk("t4_c3", 32'(count2), 32'd3);
        bit_in(1); chk("t4_c4", 32'(count2), 32'd3);
        bit_in(1); chk("t4_c5", 32'(count2), 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
        chk("t4_clr_match", 32'(match2), 32'd1);
        chk("t4_clr_count", 32'(count2), 32'd0);

        // 5: load with a coincident bit, then an all-zero pattern
        cyc(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
        chk("t5_armed", 32'(armed8), 32'd0);
        bit_in(0); bit_in(1); bit_in(1);
        chk("t5_nomatch", 32'(match8), 32'd0);
        load(4'b0000, 1'b1);
        bit_in(0); chk("t5_z1", 32'(match8), 32'd0);
        bit_in(0); chk("t5_z2", 32'(match8), 32'd0);
        bit_in(0); chk("t5_z3", 32'(match8), 32'd0);
        bit_in(0); chk("t5_z4", 32'(match8), 32'd1);

        // 6: reset mid-stream restores defaults
        load(4'b0101, 1'b0);
        bit_in(1); bit_in(0); bit_in(1);
        do_clear(2);
        bit_in(1);
        chk("t6_nomatch", 32'(match8), 32'd0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("t6_match", 32'(match8), 32'd1);
        chk("t6_count", 32'(count8), 32'd1);

        // Random phase
        rp = 4'b1011;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(999, 0));
            if (r < 4) begin
                do_clear(1);
            end else if (r < 30) begin
                rp = 4'($urandom);
                cyc(1'($urandom), 1'($urandom), 1'b1, rp, 1'($urandom), 1'($urandom_range(9, 0) == 0));
            end else begin
                cyc(($urandom_range(99, 0) < 75), 1'($urandom), 1'b0, 4'b0000, 1'b0,
                    ($urandom_range(99, 0) < 2));
            end
        end
        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_detect_prog
